logic_issue_queue: RTL and testbench

//  Upstream feeder for the registered logic unit (AND/OR/XOR/NOT, 1-cycle registered G_out).
//  - Buffers {A,B,sel} commands from a valid/ready source in a small FIFO.
//  - Issues one command at a time to the logic unit and captures its result one clock later.
//  - Presents {result, sel} to a downstream valid/ready consumer.

---
 rtl/logic_pkg.sv | 22 ++
 rtl/logic_cmd_fifo.sv | 59 +++++
 rtl/logic_issue_queue.sv | 113 +++++++++++
 tb/tb_logic_issue_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the logic-unit issue path.
//  - Opcode encodings understood by the registered logic unit.
//  - Issue FSM state encoding.
//  - Default operand and opcode widths.
package logic_pkg;

   localparam int unsigned DEF_SEL_LENGTH  = 2;
   localparam int unsigned DEF_DATA_LENGTH = DEF_SEL_LENGTH >> 1;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/logic_cmd_fifo.sv
// Synchronous command FIFO.
// Ports:
//  clk, reset        clock (posedge), asynchronous active-high reset
//  push, wdata       write request and data (ignored when full)
//  pop, rdata        read request (ignored when empty); rdata shows the head entry
//  full, empty       occupancy flags
//  count             occupancy, 0..DEPTH
module logic_cmd_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers are power-of-two wide, so the increments wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/logic_issue_queue.sv
// Issue queue feeding the registered logic unit.
// Buffers {A,B,sel} commands, issues one at a time, captures the unit's
// result one clock after it samples the operands, and offers {result, sel}
// downstream with valid/ready.
// Ports:
//  clk, reset                     clock (posedge), asynchronous active-high reset
//  cmd_valid/cmd_ready            command handshake; cmd_ready = queue not full
//  cmd_A, cmd_B, cmd_sel          command fields
//  lu_A, lu_B, lu_sel             registered drive to the logic unit
//  lu_G                           logic unit output
//  res_valid/res_ready            result handshake
//  res_data, res_sel              captured result and its opcode
//  level                          queue occupancy
module logic_issue_queue
   import logic_pkg::*;
#(
   parameter int unsigned SEL_LENGTH  = DEF_SEL_LENGTH,
   parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [DATA_LENGTH-1:0]        cmd_A,
   input  logic [DATA_LENGTH-1:0]        cmd_B,
   input  logic [SEL_LENGTH-1:0]         cmd_sel,
   output logic [DATA_LENGTH-1:0]        lu_A,
   output logic [DATA_LENGTH-1:0]        lu_B,
   output logic [SEL_LENGTH-1:0]         lu_sel,
   input  logic [DATA_LENGTH-1:0]        lu_G,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_LENGTH-1:0]        res_data,
   output logic [SEL_LENGTH-1:0]         res_sel,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned CW = 2*DATA_LENGTH + SEL_LENGTH;

   state_t          state;
   logic [CW-1:0]   head;
   logic            full;
   logic            empty;
   logic            pop;

   assign cmd_ready = !full;

   // Pop exactly when the FSM is about to load the unit: from IDLE, or from
   // HOLD in the same edge the current result is accepted.
   always_comb begin
      pop = 1'b0;
      if (!empty && (state == ST_IDLE || (state == ST_HOLD && res_ready)))
         pop = 1'b1;
   end

   logic_cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .wdata ({cmd_A, cmd_B, cmd_sel}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         lu_A      <= '0;
         lu_B      <= '0;
         lu_sel    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_sel   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  {lu_A, lu_B, lu_sel} <= head;
                  state <= ST_ISSUE;
               end
            end
            // Logic unit samples lu_* on this edge.
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               res_data  <= lu_G;
               res_sel   <= lu_sel;
               res_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (pop) begin
                     {lu_A, lu_B, lu_sel} <= head;
                     state <= ST_ISSUE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_issue_queue.sv
`timescale 1ns/1ps
module tb_logic_issue_queue;
   import logic_pkg::*;

   localparam int unsigned SL = 2;
   localparam int unsigned DL = 1;
   localparam int unsigned FD = 4;
   localparam int unsigned LW = $clog2(FD) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [DL-1:0] cmd_A = '0;
   logic [DL-1:0] cmd_B = '0;
   logic [SL-1:0] cmd_sel = '0;
   logic [DL-1:0] lu_A;
   logic [DL-1:0] lu_B;
   logic [SL-1:0] lu_sel;
   logic [DL-1:0] lu_G;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DL-1:0] res_data;
   logic [SL-1:0] res_sel;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   logic_issue_queue #(
      .SEL_LENGTH  (SL),
      .DATA_LENGTH (DL),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_A     (cmd_A),
      .cmd_B     (cmd_B),
      .cmd_sel   (cmd_sel),
      .lu_A      (lu_A),
      .lu_B      (lu_B),
      .lu_sel    (lu_sel),
      .lu_G      (lu_G),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_sel   (res_sel),
      .level     (level)
   );

   // Behavioural registered logic unit (1-cycle G_out).
   always_ff @(posedge clk)
      lu_G <= lu_sel[1] ? (lu_sel[0] ? ~lu_A : (lu_A ^ lu_B))
                        : (lu_sel[0] ? (lu_A | lu_B) : (lu_A & lu_B));

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int accepted = 0;
   int n_res = 0;
   int last_res = -1;
   bit gap_check = 1'b0;
   bit held = 1'b0;
   logic [DL-1:0] held_data;
   logic [SL-1:0] held_sel;
   logic [DL+SL-1:0] sb[$];

   // Golden model as truth tables indexed by {a,b}.
   function automatic logic [DL-1:0] golden(input logic [DL-1:0] a, input logic [DL-1:0] b,
                                            input logic [SL-1:0] s);
      logic [3:0] tt;
      case (s)
         OP_AND:  tt = 4'b1000;
         OP_OR:   tt = 4'b1110;
         OP_XOR:  tt = 4'b0110;
         default: tt = 4'b0011;
      endcase
      return tt[{a[0], b[0]}];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; scores this edge's
   // handshakes, then advances to the next negedge.
   task automatic tick();
      logic [DL+SL-1:0] exp;
      if (!reset) begin
         if (held) begin
            check("hold_valid", 32'(res_valid), 1);
            check("hold_data", 32'(res_data), 32'(held_data));
            check("hold_sel", 32'(res_sel), 32'(held_sel));
         end
         if (cmd_valid && cmd_ready) begin
            sb.push_back({golden(cmd_A, cmd_B, cmd_sel), cmd_sel});
            accepted++;
         end
         if (res_valid && res_ready) begin
            check("result_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               check("result", 32'({res_data, res_sel}), 32'(exp));
            end
            n_res++;
            if (gap_check && last_res >= 0) check("result_gap", cyc - last_res, 3);
            last_res = cyc;
         end
         held      = res_valid && !res_ready;
         held_data = res_data;
         held_sel  = res_sel;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (!res_valid && n < max) begin
         tick();
         n++;
      end
      check(tag, 32'(res_valid), 1);
   endtask

   task automatic drain(input int max, input string tag);
      int n = 0;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      while ((sb.size() != 0 || res_valid) && n < max) begin
         tick();
         n++;
      end
      check(tag, sb.size(), 0);
      res_ready = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      bit acc;
      logic [4:0] idx;

      // 1. Reset with cmd_valid asserted
      reset = 1'b1;
      cmd_valid = 1'b1; cmd_A = 1'b1; cmd_B = 1'b1; cmd_sel = OP_OR;
      @(negedge clk);
      repeat (3) tick();
      check("rst_level", 32'(level), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_lu", 32'({lu_A, lu_B, lu_sel}), 0);
      check("rst_res", 32'({res_data, res_sel}), 0);
      reset = 1'b0;
      cmd_valid = 1'b0;
      #1;
      check("rel_cmd_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      tick();
      check("rel_level", 32'(level), 0);
      check("rel_res_valid", 32'(res_valid), 0);

      // 2. Single op: OR(1,0) then NOT 1
      res_ready = 1'b0;
      cmd_valid = 1'b1; cmd_A = 1'b1; cmd_B = 1'b0; cmd_sel = OP_OR;
      tick();                                   // edge 0: push
      cmd_valid = 1'b0;
      check("s_level_e0", 32'(level), 1);
      check("s_valid_e0", 32'(res_valid), 0);
      tick();                                   // edge 1: pop, load lu_*
      check("s_level_e1", 32'(level), 0);
      check("s_lu_e1", 32'({lu_A, lu_B, lu_sel}), 32'({1'b1, 1'b0, OP_OR}));
      check("s_valid_e1", 32'(res_valid), 0);
      tick();                                   // edge 2: unit samples
      check("s_valid_e2", 32'(res_valid), 0);
      tick();                                   // edge 3: result captured
      check("s_valid_e3", 32'(res_valid), 1);
      check("s_data_e3", 32'(res_data), 1);
      check("s_sel_e3", 32'(res_sel), 32'(OP_OR));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      cmd_valid = 1'b1; cmd_A = 1'b1; cmd_B = 1'b1; cmd_sel = OP_NOT;
      tick();
      cmd_valid = 1'b0;
      wait_valid(10, "not_valid");
      check("not_data", 32'(res_data), 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // 3. Burst into a stalled consumer: one command is already in the unit,
      //    the queue fills behind it, the sixth is refused.
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1;
         cmd_A = DL'(i); cmd_B = DL'(i >> 1); cmd_sel = SL'(i + 1);
         tick();
      end
      cmd_valid = 1'b0;
      check("burst_accepted", accepted, 5);
      check("burst_level", 32'(level), 4);
      check("burst_cmd_ready", 32'(cmd_ready), 0);
      repeat (5) tick();
      check("burst_held_valid", 32'(res_valid), 1);
      drain(100, "burst_drain");

      // 4. All operand/opcode combinations, consumer always ready
      gap_check = 1'b1;
      last_res = -1;
      base = n_res;
      res_ready = 1'b1;
      idx = '0;
      n = 0;
      while ((idx < 5'd16 || sb.size() != 0 || res_valid) && n < 300) begin
         cmd_valid = (idx < 5'd16);
         cmd_A = idx[0]; cmd_B = idx[1]; cmd_sel = idx[3:2];
         acc = cmd_valid && cmd_ready;
         tick();
         if (acc) idx = idx + 5'd1;
         n++;
      end
      cmd_valid = 1'b0;
      gap_check = 1'b0;
      check("allops_results", n_res - base, 16);

      // 5. Random valid / ready traffic
      accepted = 0;
      base = n_res;
      n = 0;
      while (accepted < 1000 && n < 20000) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_A = DL'($urandom); cmd_B = DL'($urandom); cmd_sel = SL'($urandom);
         res_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("rand_accepted", accepted, 1000);
      drain(5000, "rand_drain");
      check("rand_results", n_res - base, 1000);

      // 6. Asynchronous reset while in WAIT with 3 queued
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_A = DL'(i + 1); cmd_B = DL'(i); cmd_sel = SL'(i);
         tick();
      end
      cmd_valid = 1'b0;
      check("mid_level_full", 32'(level), 4);
      res_ready = 1'b1;
      tick();                                   // HOLD pops next -> ISSUE
      res_ready = 1'b0;
      tick();                                   // ISSUE -> WAIT
      check("mid_level_wait", 32'(level), 3);
      #2 reset = 1'b1;
      #1;
      check("mid_level", 32'(level), 0);
      check("mid_res_valid", 32'(res_valid), 0);
      check("mid_res", 32'({res_data, res_sel}), 0);
      check("mid_lu", 32'({lu_A, lu_B, lu_sel}), 0);
      sb.delete();
      held = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      res_ready = 1'b1;
      repeat (20) tick();
      check("post_rst_valid", 32'(res_valid), 0);
      check("post_rst_level", 32'(level), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
